// File: rtl/keypad_pkg.sv
// Shared types and key-code mapping for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} scan_state_t;

    // Row-major legend of the lab 4x4 pad; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KEYMAP_4X4 = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input int r, input int c,
                                            input int nrows, input int ncols);
        int idx;
        idx = r * ncols + c;
        if (nrows == 4 && ncols == 4)
            return KEYMAP_4X4[idx[3:0]];
        return idx[3:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous levels such as keypad returns.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_buffer.sv
// Row-strobing keypad scanner with press/release debounce, multi-key
// rejection and a shift-register history of accepted hex codes.
module keypad_scan_buffer
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COLS-1:0]     cols,
    output logic [ROWS-1:0]     rows,
    output logic [4*DIGITS-1:0] digits,
    output logic                new_key,
    output logic                key_held,
    output logic                multi_err
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE + 1);

    scan_state_t         state_q;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [DW-1:0]       div_q;
    logic [BW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] digits_q;
    logic                new_key_q;
    logic                key_held_q;
    logic                multi_err_q;

    logic [COLS-1:0]     sc;
    logic [COLS-1:0]     low;
    logic                any_low;
    logic                one_low;
    logic                hit_ok;
    logic [CW-1:0]       low_idx;
    logic [RW-1:0]       row_next;
    logic [3:0]          code_d;
    logic [4*DIGITS+3:0] hist_ext;
    logic [4*DIGITS-1:0] digits_d;

    sync_2ff #(
        .WIDTH   (COLS),
        .RST_VAL ({COLS{1'b1}})
    ) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cols),
        .q_o   (sc)
    );

    assign low     = ~sc;
    assign any_low = |low;
    assign one_low = any_low && ((low & (low - COLS'(1))) == '0);
    // Exactly the latched column low, every other column released.
    assign hit_ok  = (sc == ~(COLS'(1) << col_q));

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < COLS; i++)
            if (low[i]) low_idx = CW'(i);
    end

    assign row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    assign code_d   = key_code(int'(row_q), int'(col_q), ROWS, COLS);
    // Shift left by one nibble; the top nibble (oldest) falls off.
    assign hist_ext = {digits_q, code_d};
    assign digits_d = hist_ext[4*DIGITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            row_q       <= '0;
            col_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            new_key_q   <= 1'b0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            new_key_q   <= 1'b0;
            multi_err_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (div_q == DW'(SCAN_DIV - 1)) begin
                        div_q <= '0;
                        if (one_low) begin
                            col_q   <= low_idx;
                            cnt_q   <= '0;
                            state_q <= PRESS_DB;
                        end else begin
                            row_q <= row_next;
                            if (any_low) multi_err_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                PRESS_DB: begin
                    if (!hit_ok) begin
                        state_q <= SCAN;
                        row_q   <= row_next;
                        div_q   <= '0;
                    end else if (cnt_q == BW'(DEBOUNCE)) begin
                        state_q    <= HELD;
                        digits_q   <= digits_d;
                        new_key_q  <= 1'b1;
                        key_held_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + BW'(1);
                    end
                end
                HELD: begin
                    // Other columns are deliberately ignored while held.
                    if (sc[col_q]) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end
                end
                REL_DB: begin
                    if (!sc[col_q]) begin
                        state_q <= HELD;
                    end else if (cnt_q == BW'(DEBOUNCE)) begin
                        key_held_q <= 1'b0;
                        state_q    <= SCAN;
                        row_q      <= row_next;
                        div_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + BW'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    always_comb begin
        rows        = '1;
        rows[row_q] = 1'b0;
    end

    assign digits    = digits_q;
    assign new_key   = new_key_q;
    assign key_held  = key_held_q;
    assign multi_err = multi_err_q;

endmodule
